// File: rtl/display_scan_ctrl_pkg.sv
// Shared encodings for the 7-segment scan controller: FSM states, anode constants
// and the one-hot anode decode.
package display_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Active-low: only the selected digit's anode is pulled low.
    function automatic logic [NUM_DIGITS-1:0] anode_on(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Scan controller bus: run/mask controls in, digit mux and anode drive out.
interface display_scan_ctrl_if;
    import display_scan_ctrl_pkg::*;

    logic                  scan_en;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [1:0]            sel;
    logic                  mux_en;
    logic [NUM_DIGITS-1:0] anode_n;
    logic                  slot_tick;

    // master = the scan controller, slave = whoever owns the controls and consumes the drive
    modport master (
        input  scan_en, digit_en,
        output sel, mux_en, anode_n, slot_tick
    );

    modport slave (
        output scan_en, digit_en,
        input  sel, mux_en, anode_n, slot_tick
    );
endinterface

// File: rtl/display_scan_ctrl_rr_next_digit.sv
// Round-robin pick: first enabled digit strictly after cur, wrapping back to cur itself.
// Feeding cur=3 yields the lowest enabled index.
module rr_next_digit
    import display_scan_ctrl_pkg::*;
(
    input  logic [1:0]            cur,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [1:0]            nxt,
    output logic                  valid
);

    logic [1:0] cand;

    // Walk from lowest to highest priority so the nearest candidate wins.
    always_comb begin
        nxt   = cur;
        valid = 1'b0;
        cand  = cur;
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (mask[cand]) begin
                nxt   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan: round-robin over enabled digits, each slot is a
// dark blanking gap followed by the lit period; all outputs registered.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 100
) (
    input  logic                clk,
    input  logic                reset,
    display_scan_ctrl_if.master bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST  = CNT_W'(PRESCALE - 2);

    scan_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            sel;
    logic                  mux_en;
    logic [NUM_DIGITS-1:0] anode_n;
    logic                  slot_tick;

    logic [1:0] start_nxt, adv_nxt;
    logic       start_vld, adv_vld;
    logic       run, slot_end;

    rr_next_digit u_start (
        .cur   (2'd3),
        .mask  (bus.digit_en),
        .nxt   (start_nxt),
        .valid (start_vld)
    );

    rr_next_digit u_adv (
        .cur   (sel),
        .mask  (bus.digit_en),
        .nxt   (adv_nxt),
        .valid (adv_vld)
    );

    assign run      = bus.scan_en && start_vld;
    // A slot ends normally at the last count, or early when its own digit gets disabled.
    assign slot_end = !bus.digit_en[sel] || (state == ST_SHOW && cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sel       <= 2'd0;
            mux_en    <= 1'b0;
            anode_n   <= ANODE_OFF;
            slot_tick <= 1'b0;
        end else begin
            slot_tick <= 1'b0;
            if (!run) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                mux_en  <= 1'b0;
                anode_n <= ANODE_OFF;
            end else if (!(state inside {ST_BLANK, ST_SHOW})) begin
                state   <= ST_BLANK;
                sel     <= start_nxt;
                cnt     <= '0;
                mux_en  <= 1'b0;
                anode_n <= ANODE_OFF;
            end else if (slot_end) begin
                state   <= ST_BLANK;
                if (adv_vld) sel <= adv_nxt;
                cnt     <= '0;
                mux_en  <= 1'b0;
                anode_n <= ANODE_OFF;
            end else begin
                cnt <= cnt + CNT_W'(1);
                // Registered pulse, so raise it one count early to land on the last lit cycle.
                slot_tick <= (cnt == CNT_PRE_LAST);
                if (state == ST_BLANK && cnt == CNT_BLANK_END) begin
                    state   <= ST_SHOW;
                    mux_en  <= 1'b1;
                    anode_n <= anode_on(sel);
                end
            end
        end
    end

    assign bus.sel       = sel;
    assign bus.mux_en    = mux_en;
    assign bus.anode_n   = anode_n;
    assign bus.slot_tick = slot_tick;

endmodule
